// File: rtl/ccd_line_packer.sv
`default_nettype none
// ============================================================================
//  Module   : ccd_line_packer
//  Purpose  : Packs the AD9826 byte stream of one CCD line into a frame
//             (header, 16-bit line number, 2*PIXELS_PER_LINE data bytes,
//             optional XOR checksum). The frame is written byte-by-byte into
//             the TX FIFO. A small byte buffer absorbs TX FIFO backpressure
//             while the readout keeps running.
//  Ports    : clk         system clock, all logic on posedge
//             rst_n       synchronous active-low reset
//             line_start  pulse, a new line is about to be sampled
//             ad_valid    strobe, ad_data holds a valid byte
//             ad_data     AD9826 output byte
//             wfull       TX FIFO full
//             wdata       byte to TX FIFO (valid while winc=1)
//             winc        TX FIFO write increment
//             clear_err   clears overflow and sync_err
//             busy        frame in progress
//             overflow    sticky, an input byte was dropped (buffer full)
//             sync_err    sticky, line_start arrived while a frame was open
//             line_count  number of completed frames
//  Option   : `define CCD_LINE_PACKER_CSUM_EN appends the XOR checksum byte.
//  Revision : 1.0  initial release
// ============================================================================
module ccd_line_packer #(
    parameter int         PIXELS_PER_LINE = 800,
    parameter int         BUF_ADDR_W      = 4,
    parameter logic [7:0] HEADER_BYTE     = 8'hC5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic        ad_valid,
    input  logic [7:0]  ad_data,
    input  logic        wfull,
    output logic [7:0]  wdata,
    output logic        winc,
    input  logic        clear_err,
    output logic        busy,
    output logic        overflow,
    output logic        sync_err,
    output logic [15:0] line_count
);

    localparam int C_FRAME_BYTES = 2 * PIXELS_PER_LINE;
    localparam int C_CNT_W       = $clog2(C_FRAME_BYTES + 1);
    localparam int C_DEPTH       = 2 ** BUF_ADDR_W;
    localparam logic [C_CNT_W-1:0]    C_TOTAL = C_CNT_W'(C_FRAME_BYTES);
    localparam logic [C_CNT_W-1:0]    C_LAST  = C_CNT_W'(C_FRAME_BYTES - 1);
    localparam logic [BUF_ADDR_W:0]   C_FULL  = (BUF_ADDR_W + 1)'(C_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_LNUM_MSB = 3'd2,
        S_LNUM_LSB = 3'd3,
`ifdef CCD_LINE_PACKER_CSUM_EN
        S_DATA     = 3'd4,
        S_CSUM     = 3'd5
`else
        S_DATA     = 3'd4
`endif
    } state_t;

    state_t r_state, w_state_nxt;

    logic [15:0]           r_line_num;
    logic [15:0]           r_line_count;
    logic [C_CNT_W-1:0]    r_in_cnt;
    logic [C_CNT_W-1:0]    r_out_cnt;
    logic                  r_overflow;
    logic                  r_sync_err;
`ifdef CCD_LINE_PACKER_CSUM_EN
    logic [7:0]            r_csum;
`endif

    // Byte buffer. Dropped bytes are not stored; instead each entry carries
    // the number of zero bytes that must be emitted before it, and r_ztail
    // counts zeros owed after the newest entry. This keeps dropped slots in
    // their original stream position without needing space for them.
    logic [7:0]            r_mem  [C_DEPTH];
    logic [C_CNT_W-1:0]    r_zpre [C_DEPTH];
    logic [BUF_ADDR_W-1:0] r_wptr;
    logic [BUF_ADDR_W-1:0] r_rptr;
    logic [BUF_ADDR_W:0]   r_count;
    logic [C_CNT_W-1:0]    r_ztail;

    logic                  w_emit;
    logic [7:0]            w_byte;
    logic                  w_pop;
    logic                  w_zhead_dec;
    logic                  w_ztail_dec;
    logic                  w_open;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_frame_done;
    logic                  w_start;
    logic [C_CNT_W-1:0]    w_head_z;

    assign w_head_z = r_zpre[r_rptr];
    assign w_open   = (r_state == S_HDR) || (r_state == S_LNUM_MSB) ||
                      (r_state == S_LNUM_LSB) || (r_state == S_DATA);
    assign w_accept = w_open && ad_valid && (r_in_cnt < C_TOTAL);
    assign w_full   = (r_count == C_FULL);
    assign w_push   = w_accept && !w_full;
    assign w_drop   = w_accept && w_full;
    assign w_start  = line_start && (r_state == S_IDLE);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_byte      = 8'h00;
        w_pop       = 1'b0;
        w_zhead_dec = 1'b0;
        w_ztail_dec = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (line_start) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                w_emit = 1'b1;
                w_byte = HEADER_BYTE;
                if (!wfull) w_state_nxt = S_LNUM_MSB;
            end
            S_LNUM_MSB: begin
                w_emit = 1'b1;
                w_byte = r_line_num[15:8];
                if (!wfull) w_state_nxt = S_LNUM_LSB;
            end
            S_LNUM_LSB: begin
                w_emit = 1'b1;
                w_byte = r_line_num[7:0];
                if (!wfull) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (r_count != '0) begin
                    w_emit = 1'b1;
                    if (w_head_z != '0) begin
                        // owed zero ahead of the head entry
                        if (!wfull) w_zhead_dec = 1'b1;
                    end else begin
                        w_byte = r_mem[r_rptr];
                        if (!wfull) w_pop = 1'b1;
                    end
                end else if (r_ztail != '0) begin
                    w_emit = 1'b1;
                    if (!wfull) w_ztail_dec = 1'b1;
                end
                if (w_emit && !wfull && (r_out_cnt == C_LAST)) begin
`ifdef CCD_LINE_PACKER_CSUM_EN
                    w_state_nxt = S_CSUM;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
`ifdef CCD_LINE_PACKER_CSUM_EN
            S_CSUM: begin
                w_emit = 1'b1;
                w_byte = r_csum;
                if (!wfull) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign winc         = w_emit && !wfull;
    assign wdata        = w_byte;
    assign w_frame_done = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // Counters, flags and buffer control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_line_num   <= 16'h0000;
            r_line_count <= 16'h0000;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_ztail      <= '0;
            r_overflow   <= 1'b0;
            r_sync_err   <= 1'b0;
`ifdef CCD_LINE_PACKER_CSUM_EN
            r_csum       <= 8'h00;
`endif
        end else begin
            // assigned every cycle so the count always reflects its own value
            r_line_count <= r_line_count + {15'd0, w_frame_done};

            if (w_start) begin
                r_line_num <= r_line_count;
                r_in_cnt   <= '0;
                r_out_cnt  <= '0;
`ifdef CCD_LINE_PACKER_CSUM_EN
                r_csum     <= 8'h00;
`endif
            end else begin
                if (w_accept) r_in_cnt <= r_in_cnt + 1'b1;
                if (winc && (r_state == S_DATA)) r_out_cnt <= r_out_cnt + 1'b1;
`ifdef CCD_LINE_PACKER_CSUM_EN
                if (w_push) r_csum <= r_csum ^ ad_data;
`endif
            end

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            // owed zeros move into the next stored entry's prefix
            if (w_push)           r_ztail <= '0;
            else if (w_drop)      r_ztail <= r_ztail + 1'b1;
            else if (w_ztail_dec) r_ztail <= r_ztail - 1'b1;

            if (w_drop)         r_overflow <= 1'b1;
            else if (clear_err) r_overflow <= 1'b0;

            if (line_start && (r_state != S_IDLE)) r_sync_err <= 1'b1;
            else if (clear_err)                    r_sync_err <= 1'b0;
        end
    end

    // Buffer storage. Push writes at r_wptr and the prefix decrement hits
    // r_rptr; they never coincide because a push needs a non-full buffer
    // and a prefix decrement needs a non-empty one.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wptr]  <= ad_data;
            r_zpre[r_wptr] <= r_ztail - C_CNT_W'(w_ztail_dec);
        end
        if (rst_n && w_zhead_dec) begin
            r_zpre[r_rptr] <= w_head_z - 1'b1;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign overflow   = r_overflow;
    assign sync_err   = r_sync_err;
    assign line_count = r_line_count;

endmodule
`default_nettype wire

// File: doc/ccd_line_packer.md
Name: ccd_line_packer

Overview:
- Sits between the CCD readout / AD9826 sampling stage and the TX FIFO write port.
- Collects the AD9826 8-bit output bytes for one CCD line. Each pixel is two bytes, MSB first then LSB.
- Frames each line as header, line number, pixel bytes and an optional checksum, and writes the frame byte-by-byte into the TX FIFO.
- A small internal byte buffer absorbs TX FIFO backpressure while the readout keeps running.

Parameters:
- PIXELS_PER_LINE, 800, pixels per CCD line; 2*PIXELS_PER_LINE data bytes per frame.
- BUF_ADDR_W, 4, internal buffer depth = 2**BUF_ADDR_W bytes.
- HEADER_BYTE, 8'hC5, first byte of every frame.

Ports:
- clk  in  1  system clock (100 MHz); all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- line_start  in  1  one-cycle pulse: a new line is about to be sampled.
- ad_valid  in  1  one-cycle strobe: ad_data holds a valid byte.
- ad_data  in  8  AD9826 output byte.
- wfull  in  1  TX FIFO full, active high.
- wdata  out  8  byte to TX FIFO.
- winc  out  1  TX FIFO write increment, active high.
- clear_err  in  1  pulse: clears overflow and sync_err.
- busy  out  1  high whenever state != IDLE.
- overflow  out  1  sticky: an input byte was dropped because the buffer was full.
- sync_err  out  1  sticky: line_start arrived while a frame was still open.
- line_count  out  16  number of completed frames.

Behaviour:
- Reset (rst_n low at a clk edge) applies from any state, including mid-frame; partial data is discarded.
  - Buffer emptied; state = IDLE; all counters 0.
  - winc=0, wdata=0, busy=0, overflow=0, sync_err=0, line_count=0.
- States: IDLE, HDR, LNUM_MSB, LNUM_LSB, DATA, CSUM.
- IDLE:
  - line_start=1 → latch line_num = line_count, clear the input byte counter and checksum, go to HDR.
  - ad_valid with no line open → byte silently dropped, no flag.
- Output rule (all emitting states):
  - winc = emitting && !wfull, driven combinationally in the same cycle. wdata is valid whenever winc=1.
  - The state advances only on a cycle where winc=1. With wfull=1 the state and buffer hold.
- HDR emits HEADER_BYTE, then goes to LNUM_MSB.
- LNUM_MSB emits line_num[15:8], then goes to LNUM_LSB.
- LNUM_LSB emits line_num[7:0], then goes to DATA.
- DATA:
  - Emitting = buffer not empty; wdata = buffer head; a pop occurs on winc.
  - Output byte counter increments per pop.
  - On the pop of byte 2*PIXELS_PER_LINE-1 → CSUM (macro on) or IDLE (macro off).
- CSUM emits the checksum, then goes to IDLE.
- On entering IDLE from a completed frame, line_count increments, wrapping 16'hFFFF → 0.
- Input side runs independently of output state while a line is open (HDR through DATA):
  - ad_valid pushes ad_data if the buffer is not full and the input counter < 2*PIXELS_PER_LINE.
  - Each push increments the input counter and XORs the byte into the checksum.
  - Buffer full → byte dropped, overflow set, input counter still increments (framing preserved).
  - The dropped slot is emitted as 8'h00 in its place and contributes 0 to the checksum.
  - Bytes beyond 2*PIXELS_PER_LINE → dropped, no flag.
- Simultaneous push and pop on the same cycle is allowed; the occupancy is unchanged.
- line_start while busy → ignored, sync_err set; the current frame continues.
- line_start in the same cycle the frame returns to IDLE → treated as busy: ignored, sync_err set.
- clear_err has lower priority than a same-cycle set event: the flag stays 1.
- Latency: from line_start to the first winc is 1 cycle with wfull=0.

Optional Feature:
- Macro: CCD_LINE_PACKER_CSUM_EN.
- Defined: CSUM state present; the frame ends with 1 byte = XOR of all 2*PIXELS_PER_LINE data bytes (zeros for dropped slots). Frame length = 2*PIXELS_PER_LINE+4.
- Undefined: no CSUM state and no checksum register; DATA goes directly to IDLE. Frame length = 2*PIXELS_PER_LINE+3.

Test Plan (PIXELS_PER_LINE=4, BUF_ADDR_W=4, macro defined unless stated):
- Nominal frame: reset, line_start, then 8 bytes 01..08, one per cycle, wfull=0 → winc stream C5,00,00,01..08,08 (XOR of 01..08 = 08); line_count=1; busy drops after the last byte.
- Backpressure: same input, wfull=1 for 20 cycles after the header → no winc while full, all 8 bytes delivered in order afterwards, overflow=0.
- Overflow: BUF_ADDR_W=2, wfull=1 throughout input 01..08 → overflow=1; after wfull=0 the output is C5,00,00,01,02,03,04,00,00,00,00,04; clear_err → overflow=0.
- Sync error: second line_start mid-DATA → sync_err=1; frame completes unchanged; next frame line number = 00,01.
- Wrap and reset: force line_count to FFFF, run a frame → line number bytes FF,FF, line_count=0. Reset mid-DATA → winc=0 next cycle, busy=0, buffer empty.
- Macro undefined: the nominal frame ends with byte 08 as the 11th byte; no checksum byte follows.
